// File: rtl/gate_lab_pkg.sv
// gate_lab_pkg: gate opcodes, button indices and small helpers shared by the gate lab.
package gate_lab_pkg;

   // Width of the gate opcode and the widest operand gate_eval handles.
   localparam int GATE_OP_W  = 3;
   localparam int GATE_MAX_W = 32;

   // Button slots in the debouncer bank.
   localparam int BTN_A    = 0;
   localparam int BTN_B    = 1;
   localparam int BTN_MODE = 2;
   localparam int N_BTNS   = 3;

   typedef enum logic [GATE_OP_W-1:0] {
      GATE_AND    = 3'd0,
      GATE_OR     = 3'd1,
      GATE_XOR    = 3'd2,
      GATE_NAND   = 3'd3,
      GATE_NOR    = 3'd4,
      GATE_XNOR   = 3'd5,
      GATE_NOT_A  = 3'd6,
      GATE_PASS_B = 3'd7
   } gate_op_e;

   // Bitwise gate evaluation; callers zero-extend narrower operands and truncate the result.
   function automatic logic [GATE_MAX_W-1:0] gate_eval(
      input gate_op_e              op,
      input logic [GATE_MAX_W-1:0] a,
      input logic [GATE_MAX_W-1:0] b
   );
      logic [GATE_MAX_W-1:0] r;
      case (op)
         GATE_AND:    r = a & b;
         GATE_OR:     r = a | b;
         GATE_XOR:    r = a ^ b;
         GATE_NAND:   r = ~(a & b);
         GATE_NOR:    r = ~(a | b);
         GATE_XNOR:   r = ~(a ^ b);
         GATE_NOT_A:  r = ~a;
         GATE_PASS_B: r = b;
         default:     r = a & b;
      endcase
      return r;
   endfunction

   // Bits needed for a counter that must hold values 0..n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/gate_lab_btn_debounce.sv
// btn_debounce: synchronises one raw button, filters contact bounce and emits a
// single-cycle pulse on each debounced press.
module btn_debounce
   import gate_lab_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic pressed,
   output logic press_pulse
);

   localparam int               CNT_W        = cnt_width(DEBOUNCE_CYCLES);
   localparam logic             RELEASED_RAW = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_reg;
   logic [1:0]       valid_reg;
   logic             sync_level;
   logic [CNT_W-1:0] cnt_reg;
   logic             stable_reg;
   logic             stable_d_reg;
   logic             armed_reg;
   logic             pulse_reg;

   // Synchronised level normalised so that 1 always means pressed.
   assign sync_level = sync_reg[1] ^ RELEASED_RAW;

   // Two-flop synchroniser; valid_reg marks when the synchroniser holds real samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg  <= {2{RELEASED_RAW}};
         valid_reg <= 2'b00;
      end else begin
         sync_reg  <= {sync_reg[0], btn_raw};
         valid_reg <= {valid_reg[0], 1'b1};
      end
   end

   // Debounce filter: adopt the new level only after DEBOUNCE_CYCLES disagreeing samples in a row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg    <= '0;
         stable_reg <= 1'b0;
      end else if (sync_level != stable_reg) begin
         if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync_level;
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end else begin
         cnt_reg <= '0;
      end
   end

   // Press edge detect; pulses are armed only once a real released sample has been seen,
   // so a button held through reset release never produces a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_d_reg <= 1'b0;
         armed_reg    <= 1'b0;
         pulse_reg    <= 1'b0;
      end else begin
         stable_d_reg <= stable_reg;
         armed_reg    <= armed_reg | (valid_reg[1] & ~sync_level);
         pulse_reg    <= armed_reg & stable_reg & ~stable_d_reg;
      end
   end

   assign pressed     = stable_reg;
   assign press_pulse = pulse_reg;

endmodule

// File: rtl/gate_lab.sv
// gate_lab: two button-stepped operands and a button-stepped gate mode, with the
// gate result, mode and a heartbeat shown on active-low LEDs.
module gate_lab
   import gate_lab_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int N_LEDS          = 8,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int HB_CYCLES       = 13500000,
   parameter int BTN_ACTIVE_LOW  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_a,
   input  logic              btn_b,
   input  logic              btn_mode,
   output logic [N_LEDS-1:0] leds
);

   localparam int                   HB_W     = cnt_width(HB_CYCLES);
   localparam logic [HB_W-1:0]      HB_LAST  = HB_W'(HB_CYCLES - 1);
   localparam logic [GATE_OP_W-1:0] MODE_ONE = GATE_OP_W'(1);

   logic [N_BTNS-1:0]    btn_raws;
   logic [N_BTNS-1:0]    press;
   logic [N_BTNS-1:0]    pressed_unused;   // debounced levels, kept for probing only

   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   gate_op_e             mode_reg;
   logic [GATE_OP_W-1:0] mode_inc;
   logic [WIDTH-1:0]     result_next;
   logic [HB_W-1:0]      hb_cnt_reg;
   logic                 hb_reg;
   logic [N_LEDS-1:0]    leds_next;
   logic [N_LEDS-1:0]    leds_reg;

   assign btn_raws[BTN_A]    = btn_a;
   assign btn_raws[BTN_B]    = btn_b;
   assign btn_raws[BTN_MODE] = btn_mode;

   generate
      for (genvar gi = 0; gi < N_BTNS; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW)
         ) u_btn (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raws[gi]),
            .pressed    (pressed_unused[gi]),
            .press_pulse(press[gi])
         );
      end
   endgenerate

   assign mode_inc = mode_reg + MODE_ONE;

   // Operand and mode registers; every pulse in a cycle is applied independently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         mode_reg <= GATE_AND;
      end else begin
         if (press[BTN_A]) a_reg <= a_reg + WIDTH'(1);
         if (press[BTN_B]) b_reg <= b_reg + WIDTH'(1);
         if (press[BTN_MODE]) mode_reg <= gate_op_e'(mode_inc);
      end
   end

   // Gate result from the registered operands; it is registered in the LED register below.
   assign result_next = WIDTH'(gate_eval(mode_reg, GATE_MAX_W'(a_reg), GATE_MAX_W'(b_reg)));

   // Free-running heartbeat: toggle every HB_CYCLES cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hb_cnt_reg <= '0;
         hb_reg     <= 1'b0;
      end else if (hb_cnt_reg == HB_LAST) begin
         hb_cnt_reg <= '0;
         hb_reg     <= ~hb_reg;
      end else begin
         hb_cnt_reg <= hb_cnt_reg + HB_W'(1);
      end
   end

   // LED map (active low): result, mode, heartbeat; unused upper LEDs stay off.
   always_comb begin
      leds_next                                = '1;
      leds_next[WIDTH-1:0]                     = ~result_next;
      leds_next[WIDTH+GATE_OP_W-1:WIDTH]       = ~mode_reg;
      leds_next[WIDTH+GATE_OP_W]               = ~hb_reg;
   end

   // Registered LED drive; this register also holds the (inverted) gate result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) leds_reg <= '1;
      else     leds_reg <= leds_next;
   end

   assign leds = leds_reg;

endmodule
